serial_mac_neuron: RTL and testbench

Time-multiplexed, parametrised neuron. One signed fixed-point multiplier and a wide accumulator replace the per-input multiplier array, so large fan-in layers fit in small area. Each output needs one (input, weight) pair per clock over a valid/ready stream, plus a bias. The block adds a registered bias, a selectable activation, optional saturation and an output handshake. It is the building block for sequential hidden and output layers.

---
 rtl/nn_fixed_pkg.sv | 59 +++++
 rtl/fixed_point_mul.sv | 19 +
 rtl/serial_mac_neuron.sv | 134 +++++++++++++
 tb/tb_serial_mac_neuron.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/nn_fixed_pkg.sv
// rtl/nn_fixed_pkg.sv - shared fixed-point types, defaults and helpers for neuron blocks
package nn_fixed_pkg;

    localparam int NN_DATA_W = 32;
    localparam int NN_FRAC_W = 24;
    // Working width for activation/saturation helpers; callers sign-extend into it.
    localparam int NN_WIDE_W = 128;

    typedef enum logic [1:0] {
        ACT_LINEAR = 2'd0,
        ACT_RELU   = 2'd1,
        ACT_LEAKY  = 2'd2
    } act_mode_e;

    typedef enum logic [1:0] {
        ACC = 2'd0,
        FIN = 2'd1,
        OUT = 2'd2
    } neuron_state_e;

    typedef struct packed {
        logic signed [NN_WIDE_W-1:0] value;
        logic                        sat;
    } sat_res_t;

    // Clamp a wide signed value into a data_w-bit signed range and flag clamping.
    function automatic sat_res_t sat_to_width(input logic signed [NN_WIDE_W-1:0] v,
                                              input int data_w);
        logic signed [NN_WIDE_W-1:0] max_v;
        logic signed [NN_WIDE_W-1:0] min_v;
        sat_res_t                    r;
        max_v   = (NN_WIDE_W'(1) << (data_w - 1)) - NN_WIDE_W'(1);
        min_v   = ~max_v;
        r.value = v;
        r.sat   = 1'b0;
        if (v > max_v) begin
            r.value = max_v;
            r.sat   = 1'b1;
        end else if (v < min_v) begin
            r.value = min_v;
            r.sat   = 1'b1;
        end
        return r;
    endfunction

    // Activation on the wide total; leaky slope is an arithmetic (floor) shift.
    function automatic logic signed [NN_WIDE_W-1:0] apply_act(input logic signed [NN_WIDE_W-1:0] v,
                                                              input act_mode_e mode,
                                                              input int shift);
        logic signed [NN_WIDE_W-1:0] r;
        case (mode)
            ACT_RELU:  r = (v > 0) ? v : '0;
            ACT_LEAKY: r = (v >= 0) ? v : (v >>> shift);
            default:   r = v;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/fixed_point_mul.sv
// rtl/fixed_point_mul.sv - signed DATA_W x DATA_W multiply, full product floor-shifted by FRAC_W
module fixed_point_mul #(
    parameter int DATA_W = 32,
    parameter int FRAC_W = 24
) (
    input  logic signed [DATA_W-1:0]          a_i,
    input  logic signed [DATA_W-1:0]          b_i,
    output logic signed [2*DATA_W-FRAC_W-1:0] p_o
);

    logic signed [2*DATA_W-1:0] prod;
    logic                       unused_frac;

    // Dropping the low FRAC_W bits of a two's complement product is an arithmetic shift (floor).
    assign prod        = a_i * b_i;
    assign p_o         = prod[2*DATA_W-1:FRAC_W];
    assign unused_frac = ^prod[FRAC_W-1:0];

endmodule

// File: rtl/serial_mac_neuron.sv
// rtl/serial_mac_neuron.sv - time-multiplexed MAC neuron with bias, activation and output handshake
module serial_mac_neuron
    import nn_fixed_pkg::*;
#(
    parameter int        DATA_W      = NN_DATA_W,
    parameter int        FRAC_W      = NN_FRAC_W,
    parameter int        N_INPUTS    = 4,
    parameter act_mode_e ACT_MODE    = ACT_RELU,
    parameter int        LEAKY_SHIFT = 3,
    parameter bit        SATURATE    = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [DATA_W-1:0] in_weight,
    input  logic [DATA_W-1:0] bias,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_sat
);

    localparam int PROD_W = 2*DATA_W - FRAC_W;
    localparam int CNT_W  = $clog2(N_INPUTS + 1);
    localparam int ACC_W  = PROD_W + CNT_W;
    localparam int TOT_W  = ACC_W + 1;

    neuron_state_e               state_q, state_d;
    logic [CNT_W-1:0]            count_q, count_d;
    logic signed [ACC_W-1:0]     acc_q, acc_d;
    logic signed [DATA_W-1:0]    bias_q, bias_d;
    logic [DATA_W-1:0]           out_data_q, out_data_d;
    logic                        out_sat_q, out_sat_d;
    logic                        out_valid_q, out_valid_d;

    logic signed [PROD_W-1:0]    term;
    logic signed [TOT_W-1:0]     total;
    logic signed [NN_WIDE_W-1:0] act_w;
    sat_res_t                    sat_res;
    logic                        unused_sat_hi;

    fixed_point_mul #(
        .DATA_W (DATA_W),
        .FRAC_W (FRAC_W)
    ) u_mul (
        .a_i (in_data),
        .b_i (in_weight),
        .p_o (term)
    );

    // Result path: accumulator plus bias, activation, then range handling on a wide copy.
    assign total         = TOT_W'(acc_q) + TOT_W'(bias_q);
    assign act_w         = apply_act(NN_WIDE_W'(total), ACT_MODE, LEAKY_SHIFT);
    assign sat_res       = sat_to_width(act_w, DATA_W);
    assign unused_sat_hi = ^sat_res.value[NN_WIDE_W-1:DATA_W];

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;

    // State register and datapath registers; reset discards any vector in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ACC;
            count_q     <= '0;
            acc_q       <= '0;
            bias_q      <= '0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            acc_q       <= acc_d;
            bias_q      <= bias_d;
            out_data_q  <= out_data_d;
            out_sat_q   <= out_sat_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Next-state and datapath control: accumulate beats, finalise once, hold until consumed.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        acc_d       = acc_q;
        bias_d      = bias_q;
        out_data_d  = out_data_q;
        out_sat_d   = out_sat_q;
        out_valid_d = out_valid_q;
        in_ready    = 1'b0;
        case (state_q)
            ACC: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (count_q == '0) begin
                        acc_d  = ACC_W'(term);
                        bias_d = bias;
                    end else begin
                        acc_d = acc_q + ACC_W'(term);
                    end
                    if (count_q == CNT_W'(N_INPUTS - 1)) begin
                        count_d = '0;
                        state_d = FIN;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
            end
            FIN: begin
                if (SATURATE) begin
                    out_data_d = sat_res.value[DATA_W-1:0];
                    out_sat_d  = sat_res.sat;
                end else begin
                    out_data_d = act_w[DATA_W-1:0];
                    out_sat_d  = 1'b0;
                end
                out_valid_d = 1'b1;
                state_d     = OUT;
            end
            OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    count_d     = '0;
                    state_d     = ACC;
                end
            end
            default: state_d = ACC;
        endcase
    end

endmodule

// File: tb/tb_serial_mac_neuron.sv
// tb/tb_serial_mac_neuron.sv - directed self-checking bench for serial_mac_neuron
module tb_serial_mac_neuron;
    import nn_fixed_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        vld_a, vld_1, ordy_a, ordy_1;
    logic [31:0] din, win, bias;

    logic        rdy_a, ov_a, os_a;
    logic [31:0] od_a;
    logic        rdy_b, ov_b, os_b;
    logic [31:0] od_b;
    logic        rdy_c, ov_c, os_c;
    logic [31:0] od_c;
    logic        rdy_d, ov_d, os_d;
    logic [31:0] od_d;
    logic        rdy_e, ov_e, os_e;
    logic [31:0] od_e;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    serial_mac_neuron #(.N_INPUTS(4), .ACT_MODE(ACT_RELU), .SATURATE(1'b1)) u_a (
        .clk(clk), .rst(rst), .in_valid(vld_a), .in_ready(rdy_a), .in_data(din),
        .in_weight(win), .bias(bias), .out_valid(ov_a), .out_ready(ordy_a),
        .out_data(od_a), .out_sat(os_a));

    serial_mac_neuron #(.N_INPUTS(1), .ACT_MODE(ACT_RELU), .SATURATE(1'b1)) u_b (
        .clk(clk), .rst(rst), .in_valid(vld_1), .in_ready(rdy_b), .in_data(din),
        .in_weight(win), .bias(bias), .out_valid(ov_b), .out_ready(ordy_1),
        .out_data(od_b), .out_sat(os_b));

    serial_mac_neuron #(.N_INPUTS(1), .ACT_MODE(ACT_LINEAR), .SATURATE(1'b1)) u_c (
        .clk(clk), .rst(rst), .in_valid(vld_1), .in_ready(rdy_c), .in_data(din),
        .in_weight(win), .bias(bias), .out_valid(ov_c), .out_ready(ordy_1),
        .out_data(od_c), .out_sat(os_c));

    serial_mac_neuron #(.N_INPUTS(1), .ACT_MODE(ACT_LEAKY), .LEAKY_SHIFT(3), .SATURATE(1'b1)) u_d (
        .clk(clk), .rst(rst), .in_valid(vld_1), .in_ready(rdy_d), .in_data(din),
        .in_weight(win), .bias(bias), .out_valid(ov_d), .out_ready(ordy_1),
        .out_data(od_d), .out_sat(os_d));

    serial_mac_neuron #(.N_INPUTS(1), .ACT_MODE(ACT_LINEAR), .SATURATE(1'b0)) u_e (
        .clk(clk), .rst(rst), .in_valid(vld_1), .in_ready(rdy_e), .in_data(din),
        .in_weight(win), .bias(bias), .out_valid(ov_e), .out_ready(ordy_1),
        .out_data(od_e), .out_sat(os_e));

    // Advance one clock and settle just after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic beat_a(input logic [31:0] d, input logic [31:0] w, input logic [31:0] b);
        din   = d;
        win   = w;
        bias  = b;
        vld_a = 1'b1;
        step();
        vld_a = 1'b0;
    endtask

    // Test-1 vector: 1.0*0.5 + 2.0*0.5 + -0.5*1.0 + 0.25*4.0 + 0.25 = 2.25.
    task automatic test1_vector(input logic gappy);
        beat_a(32'h0100_0000, 32'h0080_0000, 32'h0040_0000);
        if (gappy) step();
        beat_a(32'h0200_0000, 32'h0080_0000, 32'h7777_7777);
        if (gappy) step();
        beat_a(32'hFF80_0000, 32'h0100_0000, 32'h1234_5678);
        if (gappy) step();
        beat_a(32'h0040_0000, 32'h0400_0000, 32'hFFFF_FFFF);
    endtask

    task automatic expect_result_a(input string tag, input logic [31:0] exp_data);
        check({tag, "_fin_valid"}, {31'd0, ov_a}, 32'd0);
        check({tag, "_fin_ready"}, {31'd0, rdy_a}, 32'd0);
        step();
        check({tag, "_valid"}, {31'd0, ov_a}, 32'd1);
        check({tag, "_data"}, od_a, exp_data);
        check({tag, "_sat"}, {31'd0, os_a}, 32'd0);
    endtask

    task automatic drain_a(input string tag);
        ordy_a = 1'b1;
        step();
        ordy_a = 1'b0;
        check({tag, "_drain_valid"}, {31'd0, ov_a}, 32'd0);
        check({tag, "_drain_ready"}, {31'd0, rdy_a}, 32'd1);
    endtask

    initial begin
        rst = 1'b1; vld_a = 1'b0; vld_1 = 1'b0; ordy_a = 1'b0; ordy_1 = 1'b0;
        din = '0; win = '0; bias = '0;
        step();
        step();
        rst = 1'b0;

        check("rst_valid", {31'd0, ov_a}, 32'd0);
        check("rst_data", od_a, 32'd0);
        check("rst_sat", {31'd0, os_a}, 32'd0);
        check("rst_ready", {31'd0, rdy_a}, 32'd1);
        step();

        // 1: basic four-beat vector with bias, RELU
        test1_vector(1'b0);
        expect_result_a("t1", 32'h0240_0000);
        drain_a("t1");

        // 2: single input -1.0 x 1.0, bias 0, across activation modes
        din = 32'hFF00_0000; win = 32'h0100_0000; bias = 32'h0; vld_1 = 1'b1;
        step();
        vld_1 = 1'b0;
        check("t2_fin_valid", {31'd0, ov_b}, 32'd0);
        step();
        check("t2_valid", {31'd0, ov_b}, 32'd1);
        check("t2_relu", od_b, 32'h0000_0000);
        check("t2_linear", od_c, 32'hFF00_0000);
        check("t2_leaky", od_d, 32'hFFE0_0000);
        check("t2_wrap_linear", od_e, 32'hFF00_0000);
        check("t2_sat_flag", {31'd0, os_c}, 32'd0);
        ordy_1 = 1'b1;
        step();
        ordy_1 = 1'b0;
        check("t2_drain", {31'd0, ov_c}, 32'd0);

        // 3: 100.0 x 100.0 overflows Q7.24
        din = 32'h6400_0000; win = 32'h6400_0000; bias = 32'h0; vld_1 = 1'b1;
        step();
        vld_1 = 1'b0;
        step();
        check("t3_sat_data", od_c, 32'h7FFF_FFFF);
        check("t3_sat_flag", {31'd0, os_c}, 32'd1);
        check("t3_wrap_data", od_e, 32'h1000_0000);
        check("t3_wrap_flag", {31'd0, os_e}, 32'd0);
        check("t3_relu_sat", od_b, 32'h7FFF_FFFF);
        ordy_1 = 1'b1;
        step();
        ordy_1 = 1'b0;

        // 4: backpressure holds the result and ignores input beats
        test1_vector(1'b0);
        expect_result_a("t4a", 32'h0240_0000);
        for (int i = 0; i < 5; i++) begin
            vld_a = i[0] ? 1'b0 : 1'b1;
            din   = 32'h0700_0000 + 32'(i);
            win   = 32'h0300_0000;
            bias  = 32'h0500_0000;
            step();
            check("t4_hold_data", od_a, 32'h0240_0000);
            check("t4_hold_valid", {31'd0, ov_a}, 32'd1);
            check("t4_hold_ready", {31'd0, rdy_a}, 32'd0);
        end
        vld_a = 1'b0;
        drain_a("t4");
        test1_vector(1'b0);
        expect_result_a("t4b", 32'h0240_0000);
        drain_a("t4b");

        // 5: reset after two of four beats discards the partial vector
        beat_a(32'h0700_0000, 32'h0300_0000, 32'h0100_0000);
        beat_a(32'h0500_0000, 32'h0200_0000, 32'h0100_0000);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t5_rst_valid", {31'd0, ov_a}, 32'd0);
        check("t5_rst_ready", {31'd0, rdy_a}, 32'd1);
        test1_vector(1'b0);
        expect_result_a("t5", 32'h0240_0000);
        drain_a("t5");

        // 6: gaps between beats do not change the result or latency
        test1_vector(1'b1);
        expect_result_a("t6", 32'h0240_0000);
        drain_a("t6");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
